// File: rtl/load_dcache_port_if.sv
// Bundle of the load-buffer request/return signals and the memory read port
// used by load_dcache_port.
interface load_dcache_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PTR_W  = 3
);
    logic              Flush;
    logic              LbToDcdAble;
    logic [1:0]        LbToDcdAMat;
    logic [PTR_W-1:0]  LbToDcdAPtr;
    logic [ADDR_W-1:0] LbToDcdAPhyAddr;
    logic              DcdToLbSuccess;
    logic              DcdToLbBackAble;
    logic [PTR_W-1:0]  DcdToLbBackPtr;
    logic [DATA_W-1:0] DcdToLbBackDate;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemUncached;
    logic              MemGnt;
    logic              MemRValid;
    logic [DATA_W-1:0] MemRData;

    modport slave (
        input  Flush, LbToDcdAble, LbToDcdAMat, LbToDcdAPtr, LbToDcdAPhyAddr,
        input  MemGnt, MemRValid, MemRData,
        output DcdToLbSuccess, DcdToLbBackAble, DcdToLbBackPtr, DcdToLbBackDate,
        output MemReq, MemAddr, MemUncached
    );

    modport master (
        output Flush, LbToDcdAble, LbToDcdAMat, LbToDcdAPtr, LbToDcdAPhyAddr,
        output MemGnt, MemRValid, MemRData,
        input  DcdToLbSuccess, DcdToLbBackAble, DcdToLbBackPtr, DcdToLbBackDate,
        input  MemReq, MemAddr, MemUncached
    );
endinterface

// File: rtl/load_dcache_port.sv
// In-order data-cache load port: queues load-buffer requests and issues them one at a time.
// Build option LDPORT_WORDBUF_EN adds a one-word buffer that short-circuits repeat cached loads.
//
// state  | meaning
// IDLE   | nothing outstanding; start the head request when the queue is non-empty
// REQ    | read request presented to memory, waiting for MemGnt
// WAIT   | request granted, waiting for MemRValid
// RESP   | one-cycle return pulse to the load buffer; head popped
// DRAIN  | flushed while a read was in flight; swallow its MemRValid
module load_dcache_port #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PTR_W  = 3
) (
    input logic                Clk,
    input logic                Rest,
    load_dcache_port_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [PTR_W-1:0] q_ptr   [DEPTH];
    logic [1:0]       q_mat   [DEPTH];
    logic [WA_W-1:0]  q_waddr [DEPTH];

    logic [IDX_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic              push, pop;
    logic              resp_load;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_uncached;

    logic [PTR_W-1:0]  head_ptr;
    logic [1:0]        head_mat;
    logic [WA_W-1:0]   head_waddr;
    logic              head_uc;

    logic              back_able_q;
    logic [PTR_W-1:0]  back_ptr_q;
    logic [DATA_W-1:0] back_data_q;

    logic              wb_hit;
    logic [DATA_W-1:0] wb_data;

    // Byte offset is irrelevant: the memory side always reads whole words.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.LbToDcdAPhyAddr[1:0];

    assign head_ptr   = q_ptr[head_q];
    assign head_mat   = q_mat[head_q];
    assign head_waddr = q_waddr[head_q];
    assign head_uc    = (head_mat == 2'd0);

    // Full check deliberately ignores a same-cycle pop.
    assign push = bus.LbToDcdAble & (bus.LbToDcdAPtr != '0) & (count_q < FULL)
                & ~bus.Flush & ~Rest;

    assign bus.DcdToLbSuccess  = push;
    assign bus.DcdToLbBackAble = back_able_q;
    assign bus.DcdToLbBackPtr  = back_ptr_q;
    assign bus.DcdToLbBackDate = back_data_q;
    assign bus.MemReq          = mem_req;
    assign bus.MemAddr         = mem_addr;
    assign bus.MemUncached     = mem_uncached;

    always_ff @(posedge Clk) begin
        if (push) begin
            q_ptr[tail_q]   <= bus.LbToDcdAPtr;
            q_mat[tail_q]   <= bus.LbToDcdAMat;
            q_waddr[tail_q] <= bus.LbToDcdAPhyAddr[ADDR_W-1:2];
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.Flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef LDPORT_WORDBUF_EN
    logic             wb_valid_q;
    logic [WA_W-1:0]  wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;

    assign wb_hit  = wb_valid_q & ~head_uc & (wb_addr_q == head_waddr);
    assign wb_data = wb_data_q;

    // Uncached traffic may alias device state, so it drops the buffered word.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else if (bus.Flush || (state_q == S_REQ && head_uc)) begin
            wb_valid_q <= 1'b0;
        end else if (state_q == S_WAIT && bus.MemRValid && !head_uc) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= head_waddr;
            wb_data_q  <= bus.MemRData;
        end
    end
`else
    assign wb_hit  = 1'b0;
    assign wb_data = '0;
`endif

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        resp_load    = 1'b0;
        resp_data    = bus.MemRData;
        mem_req      = 1'b0;
        mem_addr     = '0;
        mem_uncached = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.Flush && count_q != '0) begin
                    if (wb_hit) begin
                        state_d   = S_RESP;
                        resp_load = 1'b1;
                        resp_data = wb_data;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_req      = 1'b1;
                mem_addr     = {head_waddr, 2'b00};
                mem_uncached = head_uc;
                if (bus.Flush)       state_d = S_IDLE;
                else if (bus.MemGnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.Flush) begin
                    state_d = bus.MemRValid ? S_IDLE : S_DRAIN;
                end else if (bus.MemRValid) begin
                    state_d   = S_RESP;
                    resp_load = 1'b1;
                end
            end
            S_RESP: begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.MemRValid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Return registers read zero whenever no pulse is being driven.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            back_able_q <= 1'b0;
            back_ptr_q  <= '0;
            back_data_q <= '0;
        end else if (resp_load) begin
            back_able_q <= 1'b1;
            back_ptr_q  <= head_ptr;
            back_data_q <= resp_data;
        end else begin
            back_able_q <= 1'b0;
            back_ptr_q  <= '0;
            back_data_q <= '0;
        end
    end

endmodule

// File: tb/tb_load_dcache_port.sv
// Scoreboard bench for load_dcache_port: directed scenarios plus randomized traffic
// against a reference memory whose word contents are a fixed function of the address.
`timescale 1ns/1ps
module tb_load_dcache_port;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int PTR_W  = 3;

   typedef struct {
      logic [2:0]  ptr;
      logic [1:0]  mat;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic Clk = 1'b0;
   logic Rest = 1'b1;
   always #5 Clk = ~Clk;

   load_dcache_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_W(PTR_W)) bus();

   load_dcache_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_W(PTR_W)) dut (
      .Clk  (Clk),
      .Rest (Rest),
      .bus  (bus)
   );

   exp_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int push_cnt = 0;
   int pop_cnt  = 0;

   logic        mm_auto   = 1'b1;
   logic        gnt_allow = 1'b1;
   logic        man_gnt   = 1'b0;
   logic        man_rv    = 1'b0;
   logic [31:0] man_rdata = 32'h0;
   int          rv_wait   = 0;
   logic [31:0] pend_addr = 32'h0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [31:0] mem_word(logic [31:0] addr);
      logic [31:0] w;
      w = {addr[31:2], 2'b00};
      return w ^ 32'h5A5A_C3C3 ^ {w[15:2], w[31:14]};
   endfunction

   // Reference memory: grants at random, answers 1..3 cycles later.
   initial begin
      bus.MemGnt    = 1'b0;
      bus.MemRValid = 1'b0;
      bus.MemRData  = 32'h0;
      forever begin
         @(negedge Clk);
         if (!mm_auto) begin
            bus.MemGnt    = man_gnt;
            bus.MemRValid = man_rv;
            bus.MemRData  = man_rdata;
         end else begin
            bus.MemGnt    = 1'b0;
            bus.MemRValid = 1'b0;
            bus.MemRData  = $urandom;
            if (rv_wait == 1) begin
               bus.MemRValid = 1'b1;
               bus.MemRData  = mem_word(pend_addr);
               rv_wait = 0;
            end else if (rv_wait > 1) begin
               rv_wait--;
            end else if (bus.MemReq && gnt_allow && $urandom_range(0, 2) != 0) begin
               bus.MemGnt = 1'b1;
               pend_addr  = bus.MemAddr;
               rv_wait    = $urandom_range(1, 3);
            end
         end
         if (bus.MemReq) begin
            chk("mem_req_with_queue", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("mem_addr", bus.MemAddr, {exp_q[0].addr[31:2], 2'b00});
               chk("mem_uncached", 32'(bus.MemUncached), 32'(exp_q[0].mat == 2'd0));
            end
         end else begin
            chk("mem_addr_idle", bus.MemAddr, 32'h0);
            chk("mem_uncached_idle", 32'(bus.MemUncached), 32'h0);
         end
      end
   end

   // Monitor: pops the scoreboard on every return pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         #2;
         if (!Rest) begin
            if (bus.DcdToLbBackAble) begin
               if (exp_q.size() == 0) begin
                  chk("back_able_unexpected", 32'(bus.DcdToLbBackAble), 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk("back_ptr", 32'(bus.DcdToLbBackPtr), 32'(e.ptr));
                  chk("back_data", bus.DcdToLbBackDate, e.data);
               end
               pop_cnt++;
            end else begin
               chk("back_ptr_idle", 32'(bus.DcdToLbBackPtr), 32'h0);
               chk("back_data_idle", bus.DcdToLbBackDate, 32'h0);
            end
         end
      end
   end

   task automatic drive(input logic able, input logic [2:0] ptr, input logic [1:0] mat,
                        input logic [31:0] addr, input logic use_ovr, input logic [31:0] ovr);
      int occ;
      logic exp_s;
      exp_t e;
      @(negedge Clk);
      bus.Flush           = 1'b0;
      bus.LbToDcdAble     = able;
      bus.LbToDcdAPtr     = ptr;
      bus.LbToDcdAMat     = mat;
      bus.LbToDcdAPhyAddr = addr;
      #1;
      occ   = push_cnt - pop_cnt;
      exp_s = able && (ptr != 3'd0) && (occ < DEPTH);
      chk("success", 32'(bus.DcdToLbSuccess), 32'(exp_s));
      if (exp_s) begin
         e.ptr  = ptr;
         e.mat  = mat;
         e.addr = addr;
         e.data = use_ovr ? ovr : mem_word(addr);
         exp_q.push_back(e);
         push_cnt++;
      end
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_flush();
      @(negedge Clk);
      bus.Flush           = 1'b1;
      bus.LbToDcdAble     = 1'b1;
      bus.LbToDcdAPtr     = 3'd1;
      bus.LbToDcdAMat     = 2'd1;
      bus.LbToDcdAPhyAddr = 32'h2000_0F00;
      #1;
      chk("success_in_flush", 32'(bus.DcdToLbSuccess), 32'h0);
      exp_q.delete();
      push_cnt = pop_cnt;
   endtask

   task automatic wait_empty(input int max_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         idle();
         n++;
      end
      chk("drain_timeout_left", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic wait_memreq(input int max_cyc, input string name);
      int n;
      n = 0;
      while (!bus.MemReq && n < max_cyc) begin
         idle();
         n++;
      end
      chk(name, 32'(bus.MemReq), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pool [8];
      bus.Flush           = 1'b0;
      bus.LbToDcdAble     = 1'b1;
      bus.LbToDcdAPtr     = 3'd3;
      bus.LbToDcdAMat     = 2'd1;
      bus.LbToDcdAPhyAddr = 32'h1000_0006;

      // Reset state, with a valid-looking request on the inputs.
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_success", 32'(bus.DcdToLbSuccess), 32'h0);
      chk("rst_backable", 32'(bus.DcdToLbBackAble), 32'h0);
      chk("rst_backptr", 32'(bus.DcdToLbBackPtr), 32'h0);
      chk("rst_backdata", bus.DcdToLbBackDate, 32'h0);
      chk("rst_memreq", 32'(bus.MemReq), 32'h0);
      chk("rst_memaddr", bus.MemAddr, 32'h0);
      bus.LbToDcdAble = 1'b0;
      Rest = 1'b0;
      idle();

      // Single load at minimum latency with manual memory responses.
      mm_auto = 1'b0;
      drive(1'b1, 3'd3, 2'd1, 32'h1000_0006, 1'b1, 32'hDEAD_BEEF);   // cycle 0
      idle();                                                         // cycle 1
      chk("single_c1_memreq", 32'(bus.MemReq), 32'h0);
      man_gnt = 1'b1;
      idle();                                                         // cycle 2
      chk("single_c2_memreq", 32'(bus.MemReq), 32'h1);
      chk("single_c2_memaddr", bus.MemAddr, 32'h1000_0004);
      chk("single_c2_uncached", 32'(bus.MemUncached), 32'h0);
      man_gnt = 1'b0;
      man_rv = 1'b1;
      man_rdata = 32'hDEAD_BEEF;
      idle();                                                         // cycle 3
      chk("single_c3_backable", 32'(bus.DcdToLbBackAble), 32'h0);
      chk("single_c3_memreq", 32'(bus.MemReq), 32'h0);
      man_rv = 1'b0;
      idle();                                                         // cycle 4
      chk("single_c4_backable", 32'(bus.DcdToLbBackAble), 32'h1);
      chk("single_c4_backptr", 32'(bus.DcdToLbBackPtr), 32'd3);
      chk("single_c4_backdata", bus.DcdToLbBackDate, 32'hDEAD_BEEF);
      idle();                                                         // cycle 5
      chk("single_c5_backable", 32'(bus.DcdToLbBackAble), 32'h0);
      mm_auto = 1'b1;

      // Invalid pointer is never accepted.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'd0, 2'd1, 32'h2000_0040, 1'b0, 32'h0);
         chk("invalid_ptr_memreq", 32'(bus.MemReq), 32'h0);
      end
      repeat (3) begin
         idle();
         chk("invalid_ptr_memreq_after", 32'(bus.MemReq), 32'h0);
      end

      // Backpressure: five requests into a four-entry queue with grants held off.
      gnt_allow = 1'b0;
      for (int i = 1; i <= 5; i++)
         drive(1'b1, 3'(i), 2'd1, 32'h2000_0100 + 32'(i * 4), 1'b0, 32'h0);
      chk("bp_queued", 32'(exp_q.size()), 32'd4);
      repeat (4) begin
         idle();
         chk("bp_memreq_held", 32'(bus.MemReq), 32'h1);
      end
      gnt_allow = 1'b1;
      wait_empty(200);

      // Flush while a read is in flight; its late data must be swallowed.
      repeat (2) idle();
      mm_auto = 1'b0;
      drive(1'b1, 3'd2, 2'd1, 32'h2000_0200, 1'b0, 32'h0);
      wait_memreq(10, "flush_memreq_seen");
      man_gnt = 1'b1;
      idle();
      man_gnt = 1'b0;
      do_flush();
      chk("flush_c0_backable", 32'(bus.DcdToLbBackAble), 32'h0);
      idle();
      chk("flush_c1_backable", 32'(bus.DcdToLbBackAble), 32'h0);
      man_rv = 1'b1;
      man_rdata = 32'h1234_5678;
      idle();
      chk("flush_c2_backable", 32'(bus.DcdToLbBackAble), 32'h0);
      man_rv = 1'b0;
      repeat (3) begin
         idle();
         chk("flush_after_backable", 32'(bus.DcdToLbBackAble), 32'h0);
         chk("flush_after_memreq", 32'(bus.MemReq), 32'h0);
      end
      mm_auto = 1'b1;
      drive(1'b1, 3'd6, 2'd1, 32'h2000_0300, 1'b0, 32'h0);
      wait_empty(50);

      // Uncached request.
      repeat (2) idle();
      drive(1'b1, 3'd5, 2'd0, 32'h1FE0_0000, 1'b0, 32'h0);
      wait_memreq(10, "uc_memreq_seen");
      chk("uc_memuncached", 32'(bus.MemUncached), 32'h1);
      wait_empty(50);

`ifdef LDPORT_WORDBUF_EN
      // Repeat cached load to the same word returns from the buffer.
      repeat (2) idle();
      drive(1'b1, 3'd4, 2'd1, 32'h2000_0400, 1'b0, 32'h0);
      wait_empty(50);
      repeat (2) idle();
      drive(1'b1, 3'd7, 2'd2, 32'h2000_0402, 1'b0, 32'h0);
      idle();
      chk("wb_c1_memreq", 32'(bus.MemReq), 32'h0);
      chk("wb_c1_backable", 32'(bus.DcdToLbBackAble), 32'h0);
      idle();
      chk("wb_c2_backable", 32'(bus.DcdToLbBackAble), 32'h1);
      chk("wb_c2_backptr", 32'(bus.DcdToLbBackPtr), 32'd7);
      chk("wb_c2_memreq", 32'(bus.MemReq), 32'h0);
      wait_empty(20);
`endif

      // Randomized traffic over a small address pool.
      for (int i = 0; i < 8; i++) pool[i] = 32'h3000_0000 + 32'(i * 4);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1)
            drive(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), 1'b0, 32'h0);
         else
            idle();
      end
      wait_empty(300);
      repeat (3) idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/load_dcache_port.md
Name: load_dcache_port

Overview:
- Data-cache load port sitting directly downstream of the load buffer.
- Accepts load requests (7-entry load-buffer pointer, MAT, physical address), queues them in order and issues them one at a time to the memory/cache read interface.
- Returns the loaded word tagged with the originating pointer, so the load buffer can write the physical register file and commit to the ROB.

Parameters:
- DEPTH, 4, pending request queue entries (power of 2, ≥2)
- ADDR_W, 32, physical address width
- DATA_W, 32, load data width
- PTR_W, 3, load-buffer entry pointer width (pointer 0 is reserved as invalid)

Ports:
- Clk  in  1  clock, rising edge
- Rest  in  1  reset, asynchronous, active-high
- Flush  in  1  pipeline flush; drops all queued and in-flight loads
- LbToDcdAble  in  1  load request valid
- LbToDcdAMat  in  2  memory access type: 0 = strongly-ordered uncached, 1 = coherent cached, others treated as cached
- LbToDcdAPtr  in  PTR_W  load-buffer entry of the request
- LbToDcdAPhyAddr  in  ADDR_W  physical address
- DcdToLbSuccess  out  1  request accepted this cycle (combinational)
- DcdToLbBackAble  out  1  load data return valid (registered, one-cycle pulse)
- DcdToLbBackPtr  out  PTR_W  load-buffer entry being returned
- DcdToLbBackDate  out  DATA_W  returned data
- MemReq  out  1  read request to memory side
- MemAddr  out  ADDR_W  read address, word aligned (low 2 bits forced 0)
- MemUncached  out  1  1 when head request MAT == 0
- MemGnt  in  1  memory accepts request
- MemRValid  in  1  read data valid
- MemRData  in  DATA_W  read data

Behaviour:
- Reset (Rest=1, async): queue empty, FSM in IDLE. All outputs 0: Success, BackAble, BackPtr, BackDate, MemReq, MemAddr, MemUncached.
- Accept:
  - DcdToLbSuccess = LbToDcdAble & (LbToDcdAPtr != 0) & (count < DEPTH) & ~Flush.
  - An accepted request is written to the queue tail at the clock edge, as {ptr, mat, addr}.
  - The full check ignores any same-cycle pop. With count == DEPTH, Success = 0 even if RESP pops that cycle.
- Queue: circular, wrap-around head/tail pointers plus a count of width log2(DEPTH)+1. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, REQ, WAIT, RESP, DRAIN.
  - IDLE: if count != 0 and ~Flush, go to REQ next cycle.
  - REQ: MemReq=1, MemAddr={head.addr[ADDR_W-1:2],2'b00}, MemUncached=(head.mat==0). MemGnt=1 goes to WAIT; otherwise hold in REQ with MemReq and MemAddr stable.
  - WAIT: MemRValid=1 captures MemRData, head.ptr goes to RESP.
  - RESP: DcdToLbBackAble=1 for exactly one cycle with registered BackPtr/BackDate; head is popped; go to IDLE.
  - DRAIN: wait for MemRValid and discard it (no BackAble); go to IDLE.
- MemReq, MemAddr, MemUncached are 0 outside REQ. BackPtr/BackDate read 0 when BackAble=0.
- Minimum latency: accepted at cycle 0, REQ at 2, gnt at 2, rvalid at 3, BackAble at 4.
- Flush, highest priority after reset. Queue is emptied the next edge.
  - From IDLE/REQ/RESP: go to IDLE. A RESP pulse in the flush cycle is still driven; its data is stale and the load buffer is also flushed.
  - From WAIT: go to DRAIN, unless MemRValid is 1 the same cycle, then go to IDLE.
  - Flush in DRAIN: stay in DRAIN.
- MemRValid outside WAIT/DRAIN is ignored.
- Ordering: strictly in order, one memory transaction outstanding.

Optional Feature:
- Macro LDPORT_WORDBUF_EN.
- Defined: one-entry word buffer holding {valid, word address, data}.
  - Loaded in WAIT→RESP when head MAT != 0.
  - In IDLE with a queued head whose MAT != 0 and whose word address equals the buffered address, skip REQ/WAIT and go directly to RESP using buffered data (latency from accept: 2 cycles).
  - Invalidated by Flush, by reset, and by any uncached (MAT == 0) request reaching REQ.
- Undefined: no buffer; every load goes through REQ/WAIT.

Test Plan:
- Single load: ptr=3, mat=1, addr=0x1000_0006; MemGnt at cycle 2, MemRValid with 0xDEADBEEF at cycle 3 -> Success=1 at cycle 0; MemAddr=0x1000_0004, MemUncached=0; BackAble=1 at cycle 4 with BackPtr=3, BackDate=0xDEADBEEF.
- Backpressure: issue 5 requests on consecutive cycles (ptr 1..5) with MemGnt held 0 -> Success=1 for ptrs 1–4, 0 for ptr 5; once gnt/rvalid resume, returns appear in order 1,2,3,4.
- Invalid pointer: LbToDcdAble=1, ptr=0 -> Success=0, count stays 0, MemReq never asserted.
- Flush in WAIT: Flush asserted while waiting; MemRValid arrives 2 cycles later -> no BackAble; FSM returns to IDLE; a subsequent request ptr=6 completes normally with BackPtr=6.
- Uncached: mat=0, addr=0x1FE0_0000 -> MemUncached=1 during REQ. With LDPORT_WORDBUF_EN: a second cached load to the same word as a prior cached load returns without MemReq, 2 cycles after accept.
